// File: rtl/cache_req_arbiter_pkg.sv
// Shared types and default sizes for the two-port cache front end.
package cache_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_TAG_WIDTH  = 16;
    localparam int DEF_CACHE_SIZE = 16;
    localparam int DEF_BLOCK_SIZE = 4;
    localparam int CNT_WIDTH      = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL,
        WR_MEM,
        RESP
    } cache_state_e;

endpackage

// File: rtl/cache_req_arbiter_if.sv
// Requester, response and main-memory signal bundle of the cache front end.
// Handshake: a request transfers on a clk edge where req_valid[n] and req_ready[n] are both high;
// req_valid must not wait for req_ready, and req_ready is one-hot and only offered in IDLE.
interface cache_req_arbiter_if
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH    = DEF_TAG_WIDTH,
    parameter int OFFSET_WIDTH = $clog2(DEF_BLOCK_SIZE)
);

    logic [1:0]                req_valid;
    logic [1:0]                req_ready;
    logic [1:0]                req_write;
    logic [2*TAG_WIDTH-1:0]    req_tag;
    logic [2*OFFSET_WIDTH-1:0] req_offset;
    logic [2*DATA_WIDTH-1:0]   req_wdata;

    logic                      resp_valid;
    logic                      resp_id;
    logic [DATA_WIDTH-1:0]     resp_rdata;
    logic                      resp_hit;

    logic                      mem_req;
    logic [TAG_WIDTH-1:0]      mem_tag;
    logic                      mem_rvalid;
    logic [DATA_WIDTH-1:0]     mem_rdata;
    logic                      mem_wr_req;
    logic [OFFSET_WIDTH-1:0]   mem_wr_offset;
    logic [DATA_WIDTH-1:0]     mem_wr_data;
    logic                      mem_wr_ack;

    modport master (
        output req_valid, req_write, req_tag, req_offset, req_wdata,
        output mem_rvalid, mem_rdata, mem_wr_ack,
        input  req_ready, resp_valid, resp_id, resp_rdata, resp_hit,
        input  mem_req, mem_tag, mem_wr_req, mem_wr_offset, mem_wr_data
    );

    modport slave (
        input  req_valid, req_write, req_tag, req_offset, req_wdata,
        input  mem_rvalid, mem_rdata, mem_wr_ack,
        output req_ready, resp_valid, resp_id, resp_rdata, resp_hit,
        output mem_req, mem_tag, mem_wr_req, mem_wr_offset, mem_wr_data
    );

endinterface

// File: rtl/cache_req_arbiter_data_ram.sv
// Cache data store: CACHE_SIZE lines of BLOCK_SIZE words, one write port, one combinational read port.
module cache_data_ram #(
    parameter int DATA_WIDTH   = 16,
    parameter int CACHE_SIZE   = 16,
    parameter int BLOCK_SIZE   = 4,
    parameter int INDEX_WIDTH  = $clog2(CACHE_SIZE),
    parameter int OFFSET_WIDTH = $clog2(BLOCK_SIZE)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [INDEX_WIDTH-1:0]  w_index,
    input  logic [OFFSET_WIDTH-1:0] w_offset,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [INDEX_WIDTH-1:0]  r_index,
    input  logic [OFFSET_WIDTH-1:0] r_offset,
    output logic [DATA_WIDTH-1:0]   r_data
);

    // Contents are never reset; the tag/valid store decides whether a word is meaningful.
    logic [DATA_WIDTH-1:0] mem [CACHE_SIZE*BLOCK_SIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{w_index, w_offset}] <= w_data;
        end
    end

    assign r_data = mem[{r_index, r_offset}];

endmodule

// File: rtl/cache_req_arbiter.sv
// Two-requester round-robin front end of the direct-mapped cache: lookup, refill burst, write-through.
// Define CACHE_REQ_PERF_CNT_EN to build the hit/miss/total request counters; otherwise they read 0.
module cache_req_arbiter
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH    = DEF_TAG_WIDTH,
    parameter int CACHE_SIZE   = DEF_CACHE_SIZE,
    parameter int BLOCK_SIZE   = DEF_BLOCK_SIZE,
    parameter int OFFSET_WIDTH = $clog2(BLOCK_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_req_arbiter_if.slave   bus,
    output logic [CNT_WIDTH-1:0] hit_counter,
    output logic [CNT_WIDTH-1:0] miss_counter,
    output logic [CNT_WIDTH-1:0] total_requests,
    output cache_state_e         dbg_state
);

    localparam int INDEX_WIDTH = $clog2(CACHE_SIZE);

    cache_state_e state_q, state_d;

    logic [1:0]              grant;
    logic                    win_id;
    logic                    last_id_q;
    logic                    cap_write_q;
    logic                    cap_id_q;
    logic [TAG_WIDTH-1:0]    cap_tag_q;
    logic [OFFSET_WIDTH-1:0] cap_off_q;
    logic [DATA_WIDTH-1:0]   cap_wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    hit_q;
    logic [OFFSET_WIDTH-1:0] beat_q;

    logic [CACHE_SIZE-1:0]   valid_q;
    logic [TAG_WIDTH-1:0]    tag_mem [CACHE_SIZE];

    logic [INDEX_WIDTH-1:0]  index;
    logic                    lookup_hit;
    logic                    last_beat;

    logic                    ram_we;
    logic [OFFSET_WIDTH-1:0] ram_off;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    assign index      = cap_tag_q[INDEX_WIDTH-1:0];
    assign lookup_hit = valid_q[index] && (tag_mem[index] == cap_tag_q);
    assign last_beat  = bus.mem_rvalid && (beat_q == OFFSET_WIDTH'(BLOCK_SIZE - 1));
    assign dbg_state  = state_q;

    // On contention the requester that was not served last wins; last_id_q resets to 1 so 0 goes first.
    always_comb begin
        grant = 2'b00;
        if (state_q == IDLE) begin
            case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_id_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign win_id        = grant[1];
    assign bus.req_ready = grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        ram_we            = 1'b0;
        ram_off           = beat_q;
        ram_wdata         = bus.mem_rdata;
        bus.resp_valid    = 1'b0;
        bus.resp_id       = 1'b0;
        bus.resp_rdata    = '0;
        bus.resp_hit      = 1'b0;
        bus.mem_req       = 1'b0;
        bus.mem_tag       = '0;
        bus.mem_wr_req    = 1'b0;
        bus.mem_wr_offset = '0;
        bus.mem_wr_data   = '0;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (cap_write_q) begin
                    state_d = WR_MEM;
                    if (lookup_hit) begin
                        ram_we    = 1'b1;
                        ram_off   = cap_off_q;
                        ram_wdata = cap_wdata_q;
                    end
                end else begin
                    state_d = lookup_hit ? RESP : REFILL;
                end
            end
            REFILL: begin
                bus.mem_req = 1'b1;
                bus.mem_tag = cap_tag_q;
                if (bus.mem_rvalid) begin
                    ram_we = 1'b1;
                    if (last_beat) begin
                        state_d = RESP;
                    end
                end
            end
            WR_MEM: begin
                bus.mem_wr_req    = 1'b1;
                bus.mem_tag       = cap_tag_q;
                bus.mem_wr_offset = cap_off_q;
                bus.mem_wr_data   = cap_wdata_q;
                if (bus.mem_wr_ack) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_id    = cap_id_q;
                bus.resp_rdata = rdata_q;
                bus.resp_hit   = hit_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A read miss invalidates its line up front so an aborted refill never leaves stale data marked valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_id_q   <= 1'b1;
            cap_write_q <= 1'b0;
            cap_id_q    <= 1'b0;
            cap_tag_q   <= '0;
            cap_off_q   <= '0;
            cap_wdata_q <= '0;
            rdata_q     <= '0;
            hit_q       <= 1'b0;
            beat_q      <= '0;
            valid_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|grant) begin
                        cap_id_q    <= win_id;
                        cap_write_q <= bus.req_write[win_id];
                        cap_tag_q   <= win_id ? bus.req_tag[2*TAG_WIDTH-1:TAG_WIDTH]
                                              : bus.req_tag[TAG_WIDTH-1:0];
                        cap_off_q   <= win_id ? bus.req_offset[2*OFFSET_WIDTH-1:OFFSET_WIDTH]
                                              : bus.req_offset[OFFSET_WIDTH-1:0];
                        cap_wdata_q <= win_id ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                              : bus.req_wdata[DATA_WIDTH-1:0];
                        rdata_q     <= '0;
                        beat_q      <= '0;
                    end
                end
                LOOKUP: begin
                    hit_q <= lookup_hit;
                    if (!cap_write_q) begin
                        if (lookup_hit) begin
                            rdata_q <= ram_rdata;
                        end else begin
                            valid_q[index] <= 1'b0;
                        end
                    end
                end
                REFILL: begin
                    if (bus.mem_rvalid) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == cap_off_q) begin
                            rdata_q <= bus.mem_rdata;
                        end
                        if (last_beat) begin
                            valid_q[index] <= 1'b1;
                        end
                    end
                end
                RESP: last_id_q <= cap_id_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == REFILL) && last_beat) begin
            tag_mem[index] <= cap_tag_q;
        end
    end

    cache_data_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .CACHE_SIZE (CACHE_SIZE),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_data_ram (
        .clk      (clk),
        .we       (ram_we),
        .w_index  (index),
        .w_offset (ram_off),
        .w_data   (ram_wdata),
        .r_index  (index),
        .r_offset (cap_off_q),
        .r_data   (ram_rdata)
    );

`ifdef CACHE_REQ_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_counter    <= '0;
            miss_counter   <= '0;
            total_requests <= '0;
        end else begin
            if (|grant) begin
                total_requests <= total_requests + 1'b1;
            end
            if (state_q == LOOKUP) begin
                if (lookup_hit) begin
                    hit_counter <= hit_counter + 1'b1;
                end else begin
                    miss_counter <= miss_counter + 1'b1;
                end
            end
        end
    end
`else
    assign hit_counter    = '0;
    assign miss_counter   = '0;
    assign total_requests = '0;
`endif

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed plus randomized bench for cache_req_arbiter against a behavioural cache/arbiter model.
module tb_cache_req_arbiter;
    import cache_pkg::*;

    localparam int DW = DEF_DATA_WIDTH;
    localparam int TW = DEF_TAG_WIDTH;
    localparam int NL = DEF_CACHE_SIZE;
    localparam int NB = DEF_BLOCK_SIZE;
    localparam int OW = $clog2(NB);
`ifdef CACHE_REQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic                 clk = 1'b0;
    logic                 reset;
    logic [CNT_WIDTH-1:0] hit_counter;
    logic [CNT_WIDTH-1:0] miss_counter;
    logic [CNT_WIDTH-1:0] total_requests;
    cache_state_e         dbg_state;

    always #5 clk = ~clk;

    cache_req_arbiter_if bus ();

    cache_req_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .hit_counter    (hit_counter),
        .miss_counter   (miss_counter),
        .total_requests (total_requests),
        .dbg_state      (dbg_state)
    );

    // ---------------- reference model and scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    bit            m_valid [NL];
    logic [TW-1:0] m_tag   [NL];
    logic [DW-1:0] m_data  [NL][NB];
    int            m_hits, m_misses, m_total, last_granted;

    bit            p_write [2];
    logic [TW-1:0] p_tag   [2];
    logic [OW-1:0] p_off   [2];
    logic [DW-1:0] p_wdata [2];

    logic [DW+1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int v);
        return PERF ? 32'(v) : 32'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_misses = 0;
        m_total = 0;
        last_granted = -1;
        exp_q.delete();
    endtask

    task automatic check_quiet(input string pfx);
        check({pfx, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        check({pfx, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({pfx, "_resp_rdata"}, 32'(bus.resp_rdata), 32'd0);
        check({pfx, "_resp_id_hit"}, 32'({bus.resp_id, bus.resp_hit}), 32'd0);
        check({pfx, "_mem_req"}, 32'(bus.mem_req), 32'd0);
        check({pfx, "_mem_tag"}, 32'(bus.mem_tag), 32'd0);
        check({pfx, "_mem_wr_req"}, 32'(bus.mem_wr_req), 32'd0);
        check({pfx, "_mem_wr_bus"}, 32'({bus.mem_wr_offset, bus.mem_wr_data}), 32'd0);
        check({pfx, "_hit_counter"}, hit_counter, 32'd0);
        check({pfx, "_miss_counter"}, miss_counter, 32'd0);
        check({pfx, "_total_requests"}, total_requests, 32'd0);
        check({pfx, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    // ---------------- driver tasks ----------------
    task automatic present(input int id, input bit wr, input logic [TW-1:0] tag,
                           input logic [OW-1:0] off, input logic [DW-1:0] wdata);
        p_write[id] = wr;
        p_tag[id]   = tag;
        p_off[id]   = off;
        p_wdata[id] = wdata;
        bus.req_write[id]             = wr;
        bus.req_tag[id*TW +: TW]      = tag;
        bus.req_offset[id*OW +: OW]   = off;
        bus.req_wdata[id*DW +: DW]    = wdata;
        bus.req_valid[id]             = 1'b1;
    endtask

    // Entered at a falling edge with the DUT idle; runs one transaction to its response.
    // abort_beats >= 0 asserts reset once that many refill beats have been accepted.
    task automatic serve(input int gap_max, input int ack_delay, input int abort_beats);
        int            win, idx, off, n_resp, mem_last, given;
        bit            wr, hit, refill;
        logic [TW-1:0] t;
        logic [DW-1:0] rd;
        logic [1:0]    exp_rdy;
        logic [DW+1:0] exp_resp;
        bit            beat_sched [$];

        if (bus.req_valid == 2'b11) win = (last_granted == 0) ? 1 : 0;
        else win = bus.req_valid[1] ? 1 : 0;
        exp_rdy = 2'b00;
        exp_rdy[win] = 1'b1;
        #1;
        check("req_ready_grant", 32'(bus.req_ready), 32'(exp_rdy));

        wr  = p_write[win];
        t   = p_tag[win];
        idx = int'(t) % NL;
        off = int'(p_off[win]);
        hit = m_valid[idx] && (m_tag[idx] == t);
        refill = !wr && !hit;
        rd = '0;
        if (wr) begin
            if (hit) m_data[idx][off] = p_wdata[win];
        end else if (hit) begin
            rd = m_data[idx][off];
        end else begin
            for (int k = 0; k < NB; k++) m_data[idx][k] = DW'(int'(t) * NB + k);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = t;
            rd = m_data[idx][off];
        end
        m_total++;
        if (hit) m_hits++;
        else m_misses++;
        last_granted = win;
        exp_q.push_back({1'(win), hit, rd});

        beat_sched.delete();
        if (refill) begin
            for (int k = 0; k < NB; k++) begin
                repeat ($urandom_range(0, gap_max)) beat_sched.push_back(1'b0);
                beat_sched.push_back(1'b1);
            end
        end
        mem_last = 1 + beat_sched.size();
        if (wr) n_resp = 3 + ack_delay;
        else if (hit) n_resp = 2;
        else n_resp = 2 + beat_sched.size();

        @(posedge clk);
        #1;
        bus.req_valid[win] = 1'b0;
        given = 0;

        for (int n = 1; n <= n_resp; n++) begin
            @(negedge clk);
            check("req_ready_busy", 32'(bus.req_ready), 32'd0);
            check("mem_req", 32'(bus.mem_req), 32'(refill && n >= 2 && n <= mem_last));
            if (refill && n >= 2 && n <= mem_last) check("mem_tag", 32'(bus.mem_tag), 32'(t));
            check("mem_wr_req", 32'(bus.mem_wr_req), 32'(wr && n >= 2 && n <= 2 + ack_delay));
            if (wr && n >= 2 && n <= 2 + ack_delay) begin
                check("wr_tag", 32'(bus.mem_tag), 32'(t));
                check("wr_offset", 32'(bus.mem_wr_offset), 32'(off));
                check("wr_data", 32'(bus.mem_wr_data), 32'(p_wdata[win]));
            end
            check("resp_valid", 32'(bus.resp_valid), 32'(n == n_resp));
            if (n == n_resp) begin
                exp_resp = exp_q.pop_front();
                check("resp_id_hit_rdata", 32'({bus.resp_id, bus.resp_hit, bus.resp_rdata}),
                      32'(exp_resp));
            end
            if (abort_beats >= 0 && given == abort_beats) begin
                bus.mem_rvalid = 1'b0;
                reset = 1'b1;
                #1;
                check_quiet("abort");
                model_reset();
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            bus.mem_rvalid = 1'b0;
            bus.mem_wr_ack = 1'b0;
            bus.mem_rdata  = DW'($urandom);
            if (n == 1) begin
                bus.mem_rvalid = 1'b1;  // stray beat while still looking up
            end else if (refill && n <= mem_last) begin
                bus.mem_rvalid = beat_sched[n-2];
                if (beat_sched[n-2]) begin
                    bus.mem_rdata = DW'(int'(t) * NB + given);
                    given++;
                end
            end
            if (wr && n == 2 + ack_delay) bus.mem_wr_ack = 1'b1;
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_wr_ack = 1'b0;
        check("hit_counter", hit_counter, exp_cnt(m_hits));
        check("miss_counter", miss_counter, exp_cnt(m_misses));
        check("total_requests", total_requests, exp_cnt(m_total));
        @(negedge clk);
    endtask

    function automatic logic [TW-1:0] rand_tag();
        return TW'(($urandom_range(0, 3) << 4) | $urandom_range(0, 3));
    endfunction

    // ---------------- directed and random sequence ----------------
    initial begin
        reset          = 1'b1;
        bus.req_valid  = '0;
        bus.req_write  = '0;
        bus.req_tag    = '0;
        bus.req_offset = '0;
        bus.req_wdata  = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_wr_ack = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_quiet("reset");
        reset = 1'b0;
        @(negedge clk);

        present(0, 1'b0, 16'h0010, 2'd1, 16'h0000);
        serve(0, 0, -1);
        present(0, 1'b0, 16'h0010, 2'd2, 16'h0000);
        serve(0, 0, -1);

        present(0, 1'b0, 16'h0011, 2'd0, 16'h0000);
        present(1, 1'b0, 16'h0012, 2'd0, 16'h0000);
        serve(1, 0, -1);
        serve(1, 0, -1);
        present(0, 1'b0, 16'h0011, 2'd1, 16'h0000);
        present(1, 1'b0, 16'h0012, 2'd2, 16'h0000);
        serve(0, 0, -1);
        serve(0, 0, -1);

        present(0, 1'b1, 16'h0010, 2'd3, 16'hCCCC);
        serve(0, 3, -1);
        present(0, 1'b0, 16'h0010, 2'd3, 16'h0000);
        serve(0, 0, -1);

        present(1, 1'b0, 16'h0020, 2'd0, 16'h0000);
        serve(0, 0, -1);
        present(0, 1'b0, 16'h0010, 2'd3, 16'h0000);
        serve(0, 0, -1);

        present(0, 1'b0, 16'h0010, 2'd0, 16'h0000);
        serve(0, 0, 3);
        present(0, 1'b0, 16'h0010, 2'd0, 16'h0000);
        serve(0, 0, -1);

        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!bus.req_valid[r] && ($urandom_range(0, 1) == 1)) begin
                    present(r, ($urandom_range(0, 2) == 0), rand_tag(),
                            OW'($urandom_range(0, NB - 1)), DW'($urandom));
                end
            end
            if (bus.req_valid == 2'b00) begin
                present(int'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), rand_tag(),
                        OW'($urandom_range(0, NB - 1)), DW'($urandom));
            end
            serve(2, int'($urandom_range(0, 3)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
